h14tx_pkt_scheduler: RTL and testbench

- Selects which HDMI data-island packet goes into each packet slot.
- Sources: audio sample packets (valid/ready stream), Audio Clock Regeneration (ACR), AVI InfoFrame, Audio InfoFrame (AIF), and a null packet as filler.
- Sits between the packet generators and the data-island encoder; the video timing generator provides one slot strobe per 32-pixel packet period.
- Guarantees once-per-frame InfoFrame delivery, with an aging override so that continuous audio cannot starve control packets.

---
 rtl/h14tx_pkt_scheduler.sv | 141 ++++++++++++++
 tb/tb_h14tx_pkt_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_pkt_scheduler.sv
// HDMI data-island packet scheduler: picks audio, ACR, AVI, AIF or null for each
// 32-pixel packet slot, with per-source aging so audio cannot starve control packets.
module h14tx_pkt_scheduler #(
    parameter int MaxDefer        = 8,
    parameter bit FrameInfoFrames = 1'b1,
    parameter int PktW            = 248
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            slot,
    input  logic            audio_valid,
    output logic            audio_ready,
    input  logic [PktW-1:0] audio_pkt,
    input  logic            acr_req,
    input  logic [PktW-1:0] acr_pkt,
    input  logic [PktW-1:0] avi_pkt,
    input  logic [PktW-1:0] aif_pkt,
    output logic [PktW-1:0] packet,
    output logic            packet_valid,
    output logic [2:0]      packet_sel,
    output logic            acr_overflow
);

    localparam logic [2:0] SEL_NULL  = 3'd0;
    localparam logic [2:0] SEL_AUDIO = 3'd1;
    localparam logic [2:0] SEL_ACR   = 3'd2;
    localparam logic [2:0] SEL_AVI   = 3'd3;
    localparam logic [2:0] SEL_AIF   = 3'd4;
    localparam logic [7:0] MAX_DEFER = 8'(MaxDefer);

    // Index 0 = ACR, 1 = AVI, 2 = AIF; source code is index + 2.
    logic [2:0]      w_pend;
    logic [2:0]      w_starved;
    logic [2:0]      w_set;
    logic [2:0]      w_take;
    logic            w_arm;
    logic [2:0]      w_sel;
    logic [PktW-1:0] w_pkt;

    logic [PktW-1:0] r_packet;
    logic            r_valid;
    logic [2:0]      r_sel;
    logic            r_ovf;
    logic            r_armed;

    assign w_arm    = FrameInfoFrames ? frame_start : !r_armed;
    assign w_set[0] = acr_req;
    assign w_set[1] = w_arm;
    assign w_set[2] = w_arm;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            localparam logic [2:0] CODE = 3'(gi + 2);
            logic       r_pend_bit;
            logic [7:0] r_age;

            assign w_pend[gi]    = r_pend_bit;
            assign w_starved[gi] = r_pend_bit && (r_age >= MAX_DEFER);
            assign w_take[gi]    = slot && (w_sel == CODE);

            // A set arriving with the clear keeps the flag pending (resend later).
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend_bit <= 1'b0;
                    r_age      <= 8'd0;
                end else begin
                    if (w_set[gi]) begin
                        r_pend_bit <= 1'b1;
                    end else if (w_take[gi]) begin
                        r_pend_bit <= 1'b0;
                    end
                    if (w_take[gi] || (w_set[gi] && !r_pend_bit)) begin
                        r_age <= 8'd0;
                    end else if (slot && r_pend_bit && (r_age != 8'hFF)) begin
                        r_age <= r_age + 8'd1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_sel = SEL_NULL;
        if (w_starved[0]) begin
            w_sel = SEL_ACR;
        end else if (w_starved[1]) begin
            w_sel = SEL_AVI;
        end else if (w_starved[2]) begin
            w_sel = SEL_AIF;
        end else if (audio_valid) begin
            w_sel = SEL_AUDIO;
        end else if (w_pend[0]) begin
            w_sel = SEL_ACR;
        end else if (w_pend[1]) begin
            w_sel = SEL_AVI;
        end else if (w_pend[2]) begin
            w_sel = SEL_AIF;
        end
    end

    always_comb begin
        w_pkt = '0;
        case (w_sel)
            SEL_AUDIO: w_pkt = audio_pkt;
            SEL_ACR:   w_pkt = acr_pkt;
            SEL_AVI:   w_pkt = avi_pkt;
            SEL_AIF:   w_pkt = aif_pkt;
            default:   w_pkt = '0;
        endcase
    end

    assign audio_ready = slot && (w_sel == SEL_AUDIO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_packet <= '0;
            r_valid  <= 1'b0;
            r_sel    <= SEL_NULL;
            r_ovf    <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_valid <= slot;
            r_armed <= 1'b1;
            if (slot) begin
                r_packet <= w_pkt;
                r_sel    <= w_sel;
            end
            if (acr_req && w_pend[0] && !w_take[0]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign packet       = r_packet;
    assign packet_valid = r_valid;
    assign packet_sel   = r_sel;
    assign acr_overflow = r_ovf;

endmodule

// File: tb/tb_h14tx_pkt_scheduler.sv
// Self-checking bench: table of slot scenarios feeding a scoreboard, plus
// hand-written ACR overflow and reset-in-slot sequences.
module tb_h14tx_pkt_scheduler;

    localparam int W = 248;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         slot = 1'b0;
    logic         audio_valid = 1'b0;
    logic         audio_ready;
    logic [W-1:0] audio_pkt = '0;
    logic         acr_req = 1'b0;
    logic [W-1:0] acr_pkt;
    logic [W-1:0] avi_pkt;
    logic [W-1:0] aif_pkt;
    logic [W-1:0] packet;
    logic         packet_valid;
    logic [2:0]   packet_sel;
    logic         acr_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] pkt;
        int           cyc;
    } exp_t;

    typedef struct {
        int       gap;
        bit       fs;
        bit       acr;
        bit       av;
        bit       sl;
        bit [2:0] sel;
    } vec_t;

    exp_t         sb[$];
    vec_t         vt[$];
    logic [2:0]   last_sel = 3'd0;
    logic [W-1:0] last_pkt = '0;

    h14tx_pkt_scheduler #(
        .MaxDefer(8),
        .FrameInfoFrames(1'b1),
        .PktW(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .slot(slot),
        .audio_valid(audio_valid),
        .audio_ready(audio_ready),
        .audio_pkt(audio_pkt),
        .acr_req(acr_req),
        .acr_pkt(acr_pkt),
        .avi_pkt(avi_pkt),
        .aif_pkt(aif_pkt),
        .packet(packet),
        .packet_valid(packet_valid),
        .packet_sel(packet_sel),
        .acr_overflow(acr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] rand_pkt();
        logic [W-1:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p = (p << 32) | W'($urandom);
        return p;
    endfunction

    // Scoreboard consumer: every packet_valid must match the oldest expected slot.
    always @(negedge clk) begin
        if (!rst) begin
            if (packet_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got sel=%0d at cycle %0d, required no packet_valid", packet_sel, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (packet_sel !== e.sel || packet !== e.pkt || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL slot_pkt: got sel=%0d cyc=%0d pkt=%h, required sel=%0d cyc=%0d pkt=%h",
                                 packet_sel, cyc, packet, e.sel, e.cyc, e.pkt);
                    end else begin
                        $display("slot ok: sel=%0d at cycle %0d", packet_sel, cyc);
                    end
                    last_sel = e.sel;
                    last_pkt = e.pkt;
                end
            end else begin
                checks++;
                if (packet_sel !== last_sel || packet !== last_pkt) begin
                    errors++;
                    $display("FAIL hold: got sel=%0d at cycle %0d, required held sel=%0d", packet_sel, cyc, last_sel);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_start = 1'b0;
            acr_req     = 1'b0;
            audio_valid = 1'b0;
            slot        = 1'b0;
        end
    endtask

    task automatic apply(input bit fs, input bit acr, input bit av, input bit sl, input bit [2:0] sel);
        exp_t e;
        @(negedge clk);
        frame_start = fs;
        acr_req     = acr;
        audio_valid = av;
        slot        = sl;
        audio_pkt   = rand_pkt();
        if (sl) begin
            e.sel = sel;
            e.cyc = cyc + 1;
            case (sel)
                3'd1:    e.pkt = audio_pkt;
                3'd2:    e.pkt = acr_pkt;
                3'd3:    e.pkt = avi_pkt;
                3'd4:    e.pkt = aif_pkt;
                default: e.pkt = '0;
            endcase
            sb.push_back(e);
        end
        #1;
        checks++;
        if (audio_ready !== (sl && sel == 3'd1)) begin
            errors++;
            $display("FAIL audio_ready: got %0b at cycle %0d, required %0b", audio_ready, cyc, (sl && sel == 3'd1));
        end
    endtask

    task automatic check1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end else begin
            $display("check ok: %s = %0b", name, got);
        end
    endtask

    function automatic void add(input int gap, input bit fs, input bit acr, input bit av, input bit sl, input bit [2:0] sel);
        vec_t v;
        v.gap = gap; v.fs = fs; v.acr = acr; v.av = av; v.sl = sl; v.sel = sel;
        vt.push_back(v);
    endfunction

    initial begin
        acr_pkt = rand_pkt();
        avi_pkt = rand_pkt();
        aif_pkt = rand_pkt();

        // Idle: null packets only
        repeat (3) add(2, 0, 0, 0, 1, 3'd0);
        // Frame InfoFrames: AVI, AIF, then null
        add(2, 1, 0, 0, 0, 3'd0);
        add(8, 0, 0, 0, 1, 3'd3);
        add(31, 0, 0, 0, 1, 3'd4);
        add(31, 0, 0, 0, 1, 3'd0);
        // Audio outranks fresh InfoFrames, then drain with back-to-back slots
        add(2, 1, 0, 1, 0, 3'd0);
        repeat (4) add(1, 0, 0, 1, 1, 3'd1);
        add(2, 0, 0, 0, 1, 3'd3);
        add(0, 0, 0, 0, 1, 3'd4);
        // Aging override: 8 audio, AVI, AIF, audio
        add(2, 1, 0, 1, 0, 3'd0);
        repeat (8) add(1, 0, 0, 1, 1, 3'd1);
        add(1, 0, 0, 1, 1, 3'd3);
        add(1, 0, 0, 1, 1, 3'd4);
        repeat (2) add(1, 0, 0, 1, 1, 3'd1);
        // Starved ordering: ACR before AVI before AIF
        add(2, 1, 1, 1, 0, 3'd0);
        repeat (8) add(1, 0, 0, 1, 1, 3'd1);
        add(1, 0, 0, 1, 1, 3'd2);
        add(1, 0, 0, 1, 1, 3'd3);
        add(1, 0, 0, 1, 1, 3'd4);
        add(1, 0, 0, 1, 1, 3'd1);
        // Pending ordering without audio
        add(2, 1, 1, 0, 0, 3'd0);
        add(1, 0, 0, 0, 1, 3'd2);
        add(0, 0, 0, 0, 1, 3'd3);
        add(0, 0, 0, 0, 1, 3'd4);
        add(0, 0, 0, 0, 1, 3'd0);
        // frame_start coinciding with slot while AVI pending: AVI twice
        add(2, 1, 0, 0, 0, 3'd0);
        add(1, 1, 0, 0, 1, 3'd3);
        add(1, 0, 0, 0, 1, 3'd3);
        add(1, 0, 0, 0, 1, 3'd4);
        add(1, 0, 0, 0, 1, 3'd0);

        repeat (2) @(negedge clk);
        check1("rst_valid", packet_valid, 1'b0);
        check1("rst_sel_zero", packet_sel == 3'd0, 1'b1);
        check1("rst_pkt_zero", packet == '0, 1'b1);
        check1("rst_overflow", acr_overflow, 1'b0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < vt.size(); i++) begin
            idle(vt[i].gap);
            apply(vt[i].fs, vt[i].acr, vt[i].av, vt[i].sl, vt[i].sel);
        end
        idle(3);

        // ACR delivery and sticky overflow
        apply(0, 1, 0, 0, 3'd0);
        idle(1);
        apply(0, 0, 0, 1, 3'd2);
        idle(2);
        check1("acr_no_overflow", acr_overflow, 1'b0);
        apply(0, 1, 0, 0, 3'd0);
        idle(1);
        apply(0, 1, 0, 0, 3'd0);
        idle(1);
        check1("acr_overflow_set", acr_overflow, 1'b1);
        apply(0, 0, 0, 1, 3'd2);
        idle(3);
        check1("acr_overflow_sticky", acr_overflow, 1'b1);

        // Reset in a slot cycle discards the selection
        apply(1, 0, 0, 0, 3'd0);
        @(negedge clk);
        frame_start = 1'b0;
        rst  = 1'b1;
        slot = 1'b1;
        last_sel = 3'd0;
        last_pkt = '0;
        @(negedge clk);
        slot = 1'b0;
        check1("rstslot_valid", packet_valid, 1'b0);
        check1("rstslot_sel_zero", packet_sel == 3'd0, 1'b1);
        check1("rstslot_pkt_zero", packet == '0, 1'b1);
        check1("rstslot_overflow", acr_overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check1("rstslot_no_valid_after", packet_valid, 1'b0);
        idle(2);
        apply(0, 0, 0, 1, 3'd0);
        idle(3);

        check1("scoreboard_drained", sb.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
